// File: rtl/ita_activation_pipe.sv
// Multi-lane 3-stage activation pipe (IDENTITY / RELU / i-GELU) with requantisation back to WI bits.
// Define ITA_ACT_SAT_STATS_EN to add the saturation counter ports sat_cnt_o / sat_clr_i.
module ita_activation_pipe #(
   parameter int unsigned N_LANES = 16,
   parameter int unsigned WI      = 8,
   parameter int unsigned CW      = 16,
   parameter int unsigned PW      = 32,
   parameter int unsigned EMS     = 8,
   parameter int unsigned SHW     = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_we_i,
   input  logic [1:0]              cfg_mode_i,
   input  logic [CW-1:0]           cfg_one_i,
   input  logic [CW-1:0]           cfg_b_i,
   input  logic [CW-1:0]           cfg_c_i,
   input  logic [EMS-1:0]          cfg_eps_mult_i,
   input  logic [SHW-1:0]          cfg_right_shift_i,
   input  logic [WI-1:0]           cfg_add_i,
   output logic                    cfg_err_o,
   output logic                    idle_o,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [N_LANES*WI-1:0]   data_i,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [N_LANES*WI-1:0]   data_o
`ifdef ITA_ACT_SAT_STATS_EN
   ,
   output logic [31:0]             sat_cnt_o,
   input  logic                    sat_clr_i
`endif
);

   localparam int unsigned DW  = N_LANES * WI;
   localparam int unsigned PRW = PW + EMS;
   localparam int unsigned RW  = PRW + 1;
   localparam int SAT_MAX_I = (1 << (WI - 1)) - 1;
   localparam int SAT_MIN_I = -(1 << (WI - 1));
   localparam logic signed [RW-1:0] SAT_HI = RW'(SAT_MAX_I);
   localparam logic signed [RW-1:0] SAT_LO = RW'(SAT_MIN_I);
   localparam logic [1:0] MODE_RELU = 2'd1;
   localparam logic [1:0] MODE_GELU = 2'd2;

   // Stage-1 activation pre-product; x is widened to PW so |-2^(WI-1)| cannot overflow.
   function automatic logic signed [PW-1:0] act_s1(input logic signed [WI-1:0] x,
                                                   input logic [1:0] mode,
                                                   input logic signed [CW-1:0] one,
                                                   input logic signed [CW-1:0] b,
                                                   input logic signed [CW-1:0] c);
      logic signed [PW-1:0] xe, a, nb, t, lsum;
      xe = PW'(x);
      a  = (xe < 0) ? -xe : xe;
      nb = -PW'(b);
      if (a > nb) a = nb;
      t    = a + PW'(b);
      lsum = PW'(t * t) + PW'(c);
      act_s1 = xe;
      case (mode)
         MODE_GELU: act_s1 = (xe < 0) ? (PW'(one) - lsum) : (lsum + PW'(one));
         MODE_RELU: act_s1 = (xe < 0) ? '0 : xe;
         default:   act_s1 = xe;
      endcase
   endfunction

   // Requant before saturation: multiply, arithmetic shift, round half up, add offset.
   function automatic logic signed [RW-1:0] rq_sum(input logic signed [PW-1:0] g,
                                                   input logic [EMS-1:0] eps,
                                                   input logic [SHW-1:0] sh,
                                                   input logic signed [WI-1:0] add);
      logic signed [PRW-1:0] prod, shv, half;
      logic signed [RW-1:0]  r;
      prod = PRW'(g) * PRW'($signed({1'b0, eps}));
      shv  = prod >>> sh;
      half = prod >>> (sh - SHW'(1));
      r    = RW'(shv) + RW'(add);
      if ((sh != '0) && half[0]) r = r + RW'(1);
      rq_sum = r;
   endfunction

   function automatic logic [WI-1:0] sat_clamp(input logic signed [RW-1:0] r);
      if (r > SAT_HI)      sat_clamp = WI'(SAT_HI);
      else if (r < SAT_LO) sat_clamp = WI'(SAT_LO);
      else                 sat_clamp = WI'(r);
   endfunction

   logic [1:0]            cfg_mode_q;
   logic signed [CW-1:0]  cfg_one_q, cfg_b_q, cfg_c_q;
   logic [EMS-1:0]        cfg_eps_q;
   logic [SHW-1:0]        cfg_sh_q;
   logic signed [WI-1:0]  cfg_add_q;
   logic                  ready_en_q;

   logic                            s1_valid_q, s2_valid_q;
   logic [N_LANES-1:0][WI-1:0]      s1_x_q;
   logic [N_LANES-1:0][PW-1:0]      s1_p_q, p_d;
   logic [1:0]                      s1_mode_q;
   logic [N_LANES-1:0][PW-1:0]      s2_g_q, g_d;
   logic [DW-1:0]                   data_d;
   logic                            adv1, adv2, adv3, accept;

   // A stage may load when it is empty or its content moves on this cycle.
   assign adv3    = ~valid_o | ready_i;
   assign adv2    = ~s2_valid_q | adv3;
   assign adv1    = ~s1_valid_q | adv2;
   assign ready_o = adv1 & ready_en_q;
   assign accept  = valid_i & ready_o;
   assign idle_o  = ~(s1_valid_q | s2_valid_q | valid_o);

   // Shadow config; writes only land while the pipe is empty and no beat is offered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ready_en_q <= 1'b0;
         cfg_err_o  <= 1'b0;
         cfg_mode_q <= 2'd0;
         cfg_one_q  <= '0;
         cfg_b_q    <= '0;
         cfg_c_q    <= '0;
         cfg_eps_q  <= EMS'(1);
         cfg_sh_q   <= '0;
         cfg_add_q  <= '0;
      end else begin
         ready_en_q <= 1'b1;
         if (cfg_we_i) begin
            if (idle_o && !valid_i) begin
               cfg_mode_q <= cfg_mode_i;
               cfg_one_q  <= cfg_one_i;
               cfg_b_q    <= cfg_b_i;
               cfg_c_q    <= cfg_c_i;
               cfg_eps_q  <= cfg_eps_mult_i;
               cfg_sh_q   <= cfg_right_shift_i;
               cfg_add_q  <= cfg_add_i;
            end else begin
               cfg_err_o  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      p_d    = '0;
      g_d    = '0;
      data_d = '0;
      for (int k = 0; k < N_LANES; k++) begin
         p_d[k] = act_s1(data_i[k*WI +: WI], cfg_mode_q, cfg_one_q, cfg_b_q, cfg_c_q);
         g_d[k] = (s1_mode_q == MODE_GELU) ?
                  PW'(PW'($signed(s1_x_q[k])) * $signed(s1_p_q[k])) : s1_p_q[k];
         data_d[k*WI +: WI] = sat_clamp(rq_sum(s2_g_q[k], cfg_eps_q, cfg_sh_q, cfg_add_q));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         valid_o    <= 1'b0;
         data_o     <= '0;
      end else begin
         if (adv1) s1_valid_q <= accept;
         if (adv2) s2_valid_q <= s1_valid_q;
         if (adv3) valid_o    <= s2_valid_q;
         if (adv3 && s2_valid_q) data_o <= data_d;
      end
   end

   // Payload registers carry no reset; the valids qualify them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         s1_x_q    <= data_i;
         s1_p_q    <= p_d;
         s1_mode_q <= cfg_mode_q;
      end
      if (adv2 && s1_valid_q) s2_g_q <= g_d;
   end

`ifdef ITA_ACT_SAT_STATS_EN
   logic [N_LANES-1:0] sat_d, sat_q;
   logic [32:0]        sat_sum;

   always_comb begin
      sat_d   = '0;
      sat_sum = {1'b0, sat_cnt_o};
      for (int k = 0; k < N_LANES; k++) begin
         sat_d[k] = (rq_sum(s2_g_q[k], cfg_eps_q, cfg_sh_q, cfg_add_q) > SAT_HI) ||
                    (rq_sum(s2_g_q[k], cfg_eps_q, cfg_sh_q, cfg_add_q) < SAT_LO);
         sat_sum  = sat_sum + 33'(sat_q[k]);
      end
   end

   // Saturated-lane flags travel with data_o; count on output acceptance, clamp at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sat_q     <= '0;
         sat_cnt_o <= '0;
      end else begin
         if (adv3 && s2_valid_q) sat_q <= sat_d;
         if (sat_clr_i)                sat_cnt_o <= '0;
         else if (valid_o && ready_i)  sat_cnt_o <= sat_sum[32] ? '1 : sat_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_ita_activation_pipe.sv
// Directed self-checking bench for ita_activation_pipe; hand-computed expected lane values.
`timescale 1ns/1ps
module tb_ita_activation_pipe;

   localparam int unsigned N_LANES = 16;
   localparam int unsigned WI      = 8;
   localparam int unsigned DW      = N_LANES * WI;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cfg_we_i;
   logic [1:0]    cfg_mode_i;
   logic [15:0]   cfg_one_i, cfg_b_i, cfg_c_i;
   logic [7:0]    cfg_eps_mult_i;
   logic [4:0]    cfg_right_shift_i;
   logic [7:0]    cfg_add_i;
   logic          cfg_err_o, idle_o;
   logic          valid_i, ready_o, valid_o, ready_i;
   logic [DW-1:0] data_i, data_o;
`ifdef ITA_ACT_SAT_STATS_EN
   logic [31:0]   sat_cnt_o;
   logic          sat_clr_i;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ita_activation_pipe dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .cfg_we_i          (cfg_we_i),
      .cfg_mode_i        (cfg_mode_i),
      .cfg_one_i         (cfg_one_i),
      .cfg_b_i           (cfg_b_i),
      .cfg_c_i           (cfg_c_i),
      .cfg_eps_mult_i    (cfg_eps_mult_i),
      .cfg_right_shift_i (cfg_right_shift_i),
      .cfg_add_i         (cfg_add_i),
      .cfg_err_o         (cfg_err_o),
      .idle_o            (idle_o),
      .valid_i           (valid_i),
      .ready_o           (ready_o),
      .data_i            (data_i),
      .valid_o           (valid_o),
      .ready_i           (ready_i),
      .data_o            (data_o)
`ifdef ITA_ACT_SAT_STATS_EN
      ,
      .sat_cnt_o         (sat_cnt_o),
      .sat_clr_i         (sat_clr_i)
`endif
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Lanes 0..5 given explicitly, all remaining lanes set to 'rest'.
   function automatic logic [DW-1:0] lanes(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int rest);
      logic [DW-1:0] v;
      for (int k = 6; k < N_LANES; k++) v[k*WI +: WI] = 8'(rest);
      v[0*WI +: WI] = 8'(a0);
      v[1*WI +: WI] = 8'(a1);
      v[2*WI +: WI] = 8'(a2);
      v[3*WI +: WI] = 8'(a3);
      v[4*WI +: WI] = 8'(a4);
      v[5*WI +: WI] = 8'(a5);
      return v;
   endfunction

   function automatic logic [DW-1:0] beat(input int i);
      logic [DW-1:0] v;
      for (int k = 0; k < N_LANES; k++) v[k*WI +: WI] = 8'(i * 16 + k);
      return v;
   endfunction

   task automatic set_cfg(input int mode, input int one, input int b, input int c,
                          input int eps, input int sh, input int add);
      cfg_mode_i        = 2'(mode);
      cfg_one_i         = 16'(one);
      cfg_b_i           = 16'(b);
      cfg_c_i           = 16'(c);
      cfg_eps_mult_i    = 8'(eps);
      cfg_right_shift_i = 5'(sh);
      cfg_add_i         = 8'(add);
      cfg_we_i          = 1'b1;
      step();
      cfg_we_i          = 1'b0;
   endtask

   // Offer one beat, wait (bounded) for it at the output, consume it.
   task automatic run_beat(input logic [DW-1:0] d, output logic [DW-1:0] q, output int lat);
      valid_i = 1'b1;
      data_i  = d;
      ready_i = 1'b1;
      step();
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 20) begin
         step();
         lat++;
      end
      q = data_o;
      step();
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] q, held_d;
      int            lat, sent, recv, cyc;
      logic          held, seen;

      rst_i = 1'b1; cfg_we_i = 1'b0; cfg_mode_i = '0; cfg_one_i = '0; cfg_b_i = '0;
      cfg_c_i = '0; cfg_eps_mult_i = '0; cfg_right_shift_i = '0; cfg_add_i = '0;
      valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
`ifdef ITA_ACT_SAT_STATS_EN
      sat_clr_i = 1'b0;
`endif
      repeat (3) step();
      rst_i = 1'b0;
      check("rst_ready_low", ready_o, 0);
      step();
      check("rst_valid_o", valid_o, 0);
      check("rst_data_o",  data_o, 0);
      check("rst_idle",    idle_o, 1);
      check("rst_cfg_err", cfg_err_o, 0);
      check("rst_ready",   ready_o, 1);

      // 1: reset config is IDENTITY, eps=1, shift 0, add 0
      run_beat(lanes(-5, 100, -128, 127, 1, -1, 60), q, lat);
      check("t1_lat",  DW'(lat), DW'(3));
      check("t1_data", q, lanes(-5, 100, -128, 127, 1, -1, 60));

      // 2: RELU
      set_cfg(1, 0, 0, 0, 1, 0, 0);
      run_beat(lanes(-5, 7, -128, 127, 0, -1, 0), q, lat);
      check("t2_relu", q, lanes(0, 7, 0, 127, 0, 0, 0));

      // 3: GELU one=0 b=-4 c=16, shift 2; zero lanes give L=32, g=0
      set_cfg(2, 0, -4, 16, 1, 2, 0);
      run_beat(lanes(2, -2, 9, -128, -9, 3, 0), q, lat);
      check("t3_gelu", q, lanes(10, 10, 36, 127, 36, 13, 0));
      check("t3_lat",  DW'(lat), DW'(3));

`ifdef ITA_ACT_SAT_STATS_EN
      sat_clr_i = 1'b1;
      step();
      sat_clr_i = 1'b0;
      check("t4_sat_clr", DW'(sat_cnt_o), DW'(0));
`endif
      // 4: rounding and saturation in IDENTITY
      set_cfg(0, 0, 0, 0, 1, 1, 0);
      run_beat(lanes(3, -3, 1, -1, 0, 0, 0), q, lat);
      check("t4_round", q, lanes(2, -1, 1, 0, 0, 0, 0));
      set_cfg(0, 0, 0, 0, 100, 0, 0);
      run_beat(lanes(5, -5, 1, -1, 0, 0, 0), q, lat);
      check("t4_sat_mult", q, lanes(127, -128, 100, -100, 0, 0, 0));
      set_cfg(0, 0, 0, 0, 1, 0, -10);
      run_beat(lanes(-125, 0, 127, 0, 0, 0, 0), q, lat);
      check("t4_sat_add", q, lanes(-128, -10, 117, -10, -10, -10, -10));
`ifdef ITA_ACT_SAT_STATS_EN
      check("t4_sat_cnt", DW'(sat_cnt_o), DW'(3));
`endif

      // 5: 20-beat stream under backpressure
      set_cfg(0, 0, 0, 0, 1, 0, 0);
      sent = 0; recv = 0; cyc = 0; held = 1'b0; held_d = '0;
      while (recv < 20 && cyc < 400) begin
         if (cyc >= 4 && cyc <= 8) ready_i = 1'b0;
         else if (cyc > 8)         ready_i = ($urandom_range(0, 99) >= 30);
         else                      ready_i = 1'b1;
         if (sent < 20) begin
            valid_i = 1'b1;
            data_i  = beat(sent);
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk);
         if (held) begin
            check("t5_hold_valid", valid_o, 1);
            check("t5_hold_data",  data_o, held_d);
         end
         held   = valid_o && !ready_i;
         held_d = data_o;
         if (valid_o && ready_i) begin
            check("t5_data", data_o, beat(recv));
            recv++;
         end
         if (valid_i && ready_o) sent++;
         step();
         cyc++;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      check("t5_recv", DW'(recv), DW'(20));
      check("t5_sent", DW'(sent), DW'(20));
      seen = 1'b0;
      repeat (5) begin
         if (valid_o) seen = 1'b1;
         step();
      end
      check("t5_no_extra", seen, 0);

      // 6: cfg write with a beat in flight is dropped and flagged
      valid_i = 1'b1;
      data_i  = lanes(-5, 4, 0, 0, 0, 0, 0);
      step();
      valid_i    = 1'b0;
      cfg_mode_i = 2'd1;
      cfg_we_i   = 1'b1;
      step();
      cfg_we_i = 1'b0;
      check("t6_cfg_err", cfg_err_o, 1);
      lat = 2;
      while (!valid_o && lat < 20) begin
         step();
         lat++;
      end
      check("t6_inflight", data_o, lanes(-5, 4, 0, 0, 0, 0, 0));
      step();
      run_beat(lanes(-5, 4, 0, 0, 0, 0, 0), q, lat);
      check("t6_cfg_kept", q, lanes(-5, 4, 0, 0, 0, 0, 0));
      check("t6_err_sticky", cfg_err_o, 1);

      // reset with beats in flight
      valid_i = 1'b1;
      data_i  = beat(1);
      step();
      data_i  = beat(2);
      step();
      valid_i = 1'b0;
      rst_i   = 1'b1;
      step();
      check("t6_rst_valid", valid_o, 0);
      check("t6_rst_idle",  idle_o, 1);
      check("t6_rst_err",   cfg_err_o, 0);
      rst_i = 1'b0;
      seen  = 1'b0;
      repeat (8) begin
         step();
         if (valid_o) seen = 1'b1;
      end
      check("t6_rst_no_out", seen, 0);
      check("t6_rst_ready",  ready_o, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
